// File: rtl/job_completion_writer.sv
// Completion ring writer: buffers scheduler completion pushes in a FIFO and
// issues one phase-tagged 64-bit record write per entry into a host ring.
module job_completion_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int RING_IDX_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  complete_push_i,
  output logic                  complete_ready_o,
  input  logic [40:0]           return_data_i,
  input  logic                  cmpl_enable_i,
  input  logic [63:0]           cmpl_base_addr_i,
  input  logic [RING_IDX_W-1:0] cmpl_head_i,
  output logic                  wr_req_valid_o,
  input  logic                  wr_req_ready_i,
  output logic [63:0]           wr_req_addr_o,
  output logic [63:0]           wr_req_data_o,
  output logic [31:0]           cmpl_cnt_o,
  output logic                  overflow_err_o
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                state, state_next;
  logic [40:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count, count_next;
  logic                  ready_q, nonempty_q;
  logic                  push_acc, pop, hs;
  logic [RING_IDX_W-1:0] wr_idx, idx_inc;
  logic                  phase;
  logic [15:0]           seq;
  logic                  ring_full;
  logic [40:0]           head_entry;

  assign push_acc         = complete_push_i & ready_q;
  assign idx_inc          = wr_idx + RING_IDX_W'(1);
  assign ring_full        = (idx_inc == cmpl_head_i);
  assign head_entry       = mem[rd_ptr];
  assign complete_ready_o = ready_q;
  assign wr_req_valid_o   = (state == REQ);
  assign count_next       = count + (PTR_W+1)'(push_acc) - (PTR_W+1)'(pop);

  // Issue FSM: IDLE pops one entry into the request registers, REQ waits for the handshake
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    hs         = 1'b0;
    case (state)
      IDLE: if (nonempty_q && cmpl_enable_i && !ring_full) begin
        state_next = REQ;
        pop        = 1'b1;
      end
      REQ: if (wr_req_ready_i) begin
        state_next = IDLE;
        hs         = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FIFO storage; entries past the read pointer are dead, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= return_data_i;
  end

  // FIFO pointers, occupancy and registered status flags. The non-empty flag
  // lags the count by a cycle; it only gates IDLE, and REQ always lasts at
  // least one cycle, so it can never report an entry that was already popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready_q    <= 1'b0;
      nonempty_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      ready_q    <= (count_next != (PTR_W+1)'(FIFO_DEPTH));
      nonempty_q <= (count != '0);
    end
  end

  // Request registers plus ring producer state (index, phase, sequence, count)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_req_addr_o <= '0;
      wr_req_data_o <= '0;
      wr_idx        <= '0;
      phase         <= 1'b1;
      seq           <= '0;
      cmpl_cnt_o    <= '0;
    end else begin
      if (pop) begin
        wr_req_addr_o <= cmpl_base_addr_i + 64'({wr_idx, 3'b000});
        wr_req_data_o <= {head_entry[31:0], head_entry[40:32], 6'b0, phase, seq};
      end
      if (hs) begin
        wr_idx     <= idx_inc;
        if (&wr_idx) phase <= ~phase;
        seq        <= seq + 16'd1;
        cmpl_cnt_o <= cmpl_cnt_o + 32'd1;
      end
    end
  end

  // Sticky flag for pushes that arrived while the FIFO was full
  always_ff @(posedge clk) begin
    if (rst)                               overflow_err_o <= 1'b0;
    else if (complete_push_i && !ready_q)  overflow_err_o <= 1'b1;
  end
endmodule

// File: tb/tb_job_completion_writer.sv
// Scoreboard bench for job_completion_writer with a 4-entry ring (RING_IDX_W=2).
module tb_job_completion_writer;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          complete_push_i = 1'b0;
  logic          complete_ready_o;
  logic [40:0]   return_data_i = '0;
  logic          cmpl_enable_i = 1'b1;
  logic [63:0]   cmpl_base_addr_i = 64'h1000_0000;
  logic [RW-1:0] cmpl_head_i = '0;
  logic          wr_req_valid_o;
  logic          wr_req_ready_i = 1'b0;
  logic [63:0]   wr_req_addr_o;
  logic [63:0]   wr_req_data_o;
  logic [31:0]   cmpl_cnt_o;
  logic          overflow_err_o;

  job_completion_writer #(.FIFO_DEPTH(16), .RING_IDX_W(RW)) dut (
    .clk(clk), .rst(rst),
    .complete_push_i(complete_push_i), .complete_ready_o(complete_ready_o),
    .return_data_i(return_data_i), .cmpl_enable_i(cmpl_enable_i),
    .cmpl_base_addr_i(cmpl_base_addr_i), .cmpl_head_i(cmpl_head_i),
    .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i),
    .wr_req_addr_o(wr_req_addr_o), .wr_req_data_o(wr_req_data_o),
    .cmpl_cnt_o(cmpl_cnt_o), .overflow_err_o(overflow_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [63:0] data; } rec_t;
  rec_t        q[$];
  int          checks = 0, failures = 0;
  logic [31:0] push_n = 0;   // pushes accepted since reset = record number
  logic [31:0] hs_cnt = 0;   // handshakes observed since reset
  logic        rdy_fixed = 1'b0, rand_rdy = 1'b0, auto_head = 1'b1;
  logic        stall_prev = 1'b0;
  logic [63:0] prev_addr, prev_data;

  // Software/host side: write-ready and consumer head, updated after the tasks settle
  always @(posedge clk) begin
    #2;
    wr_req_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    if (auto_head) cmpl_head_i = RW'(hs_cnt);
  end

  // Monitor: stability while stalled, and scoreboard compare on each handshake
  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        checks++;
        if (wr_req_valid_o !== 1'b1 || wr_req_addr_o !== prev_addr || wr_req_data_o !== prev_data) begin
          failures++;
          $display("FAIL stall_stable: valid=%b addr=%h data=%h want valid=1 addr=%h data=%h",
                   wr_req_valid_o, wr_req_addr_o, wr_req_data_o, prev_addr, prev_data);
        end
      end
      if (wr_req_valid_o && wr_req_ready_i) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_record: addr=%h data=%h with empty scoreboard", wr_req_addr_o, wr_req_data_o);
        end else begin
          rec_t e;
          e = q.pop_front();
          if (wr_req_addr_o !== e.addr || wr_req_data_o !== e.data) begin
            failures++;
            $display("FAIL record%0d: addr=%h data=%h want addr=%h data=%h",
                     hs_cnt, wr_req_addr_o, wr_req_data_o, e.addr, e.data);
          end
        end
        hs_cnt++;
      end
      stall_prev = wr_req_valid_o && !wr_req_ready_i;
      prev_addr  = wr_req_addr_o;
      prev_data  = wr_req_data_o;
    end
  end

  task automatic push_raw(input logic [8:0] pid, input logic [31:0] job);
    logic acc;
    rec_t e;
    complete_push_i = 1'b1;
    return_data_i   = {pid, job};
    acc = complete_ready_o;
    @(posedge clk);
    if (acc) begin
      e.addr = cmpl_base_addr_i + 64'(push_n[RW-1:0]) * 64'd8;
      e.data = {job, pid, 6'b0, ~push_n[RW], push_n[15:0]};
      q.push_back(e);
      push_n++;
    end
    #1 complete_push_i = 1'b0;
  endtask

  task automatic do_push(input logic [8:0] pid, input logic [31:0] job);
    int t = 0;
    while (!complete_ready_o && t < 300) begin @(posedge clk); #1; t++; end
    if (!complete_ready_o) begin
      checks++; failures++;
      $display("FAIL push_timeout: ready=%b want 1", complete_ready_o);
    end else push_raw(pid, job);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while ((q.size() != 0 || wr_req_valid_o) && t < budget) begin @(posedge clk); #1; t++; end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0 || wr_req_valid_o) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d valid=%b want 0 0", q.size(), wr_req_valid_o);
    end
    checks++;
    if (cmpl_cnt_o !== hs_cnt) begin
      failures++;
      $display("FAIL cnt_after_drain: cnt=%0d want %0d", cmpl_cnt_o, hs_cnt);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete(); push_n = 0; hs_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (complete_ready_o !== 1'b0 || wr_req_valid_o !== 1'b0 || wr_req_addr_o !== 64'd0 ||
        wr_req_data_o !== 64'd0 || cmpl_cnt_o !== 32'd0 || overflow_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: ready=%b valid=%b addr=%h data=%h cnt=%0d ovf=%b want all 0",
               complete_ready_o, wr_req_valid_o, wr_req_addr_o, wr_req_data_o, cmpl_cnt_o, overflow_err_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (complete_ready_o !== 1'b1) begin
      failures++; $display("FAIL ready_after_reset: ready=%b want 1", complete_ready_o);
    end
  endtask

  task automatic test_single();
    rdy_fixed = 1'b0;
    cmpl_base_addr_i = 64'h1000_0000;
    push_raw(9'h1A5, 32'hDEAD_BEEF);   // accepted at edge k
    checks++;
    if (wr_req_valid_o !== 1'b0) begin failures++; $display("FAIL latency_k: valid=%b want 0", wr_req_valid_o); end
    @(posedge clk); #1;
    checks++;
    if (wr_req_valid_o !== 1'b0) begin failures++; $display("FAIL latency_k1: valid=%b want 0", wr_req_valid_o); end
    @(posedge clk); #1;
    checks++;
    if (wr_req_valid_o !== 1'b1 || wr_req_addr_o !== 64'h1000_0000 || wr_req_data_o !== 64'hDEADBEEF_D2810000) begin
      failures++;
      $display("FAIL single_req: valid=%b addr=%h data=%h want 1 0000000010000000 deadbeefd2810000",
               wr_req_valid_o, wr_req_addr_o, wr_req_data_o);
    end
    rdy_fixed = 1'b1;
    wait_drain(50);
    checks++;
    if (cmpl_cnt_o !== 32'd1) begin failures++; $display("FAIL single_cnt: cnt=%0d want 1", cmpl_cnt_o); end
  endtask

  task automatic test_ring_full();
    apply_reset();
    @(posedge clk); #1;
    auto_head = 1'b0; cmpl_head_i = '0; rdy_fixed = 1'b1;
    for (int i = 0; i < 5; i++) do_push(9'(i + 3), 32'hA000_0000 + 32'(i));
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (hs_cnt !== 32'd3 || wr_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL ring_stall: issued=%0d valid=%b want 3 0", hs_cnt, wr_req_valid_o);
    end
    cmpl_head_i = 2'd1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (hs_cnt !== 32'd4) begin failures++; $display("FAIL ring_head1: issued=%0d want 4", hs_cnt); end
    cmpl_head_i = 2'd2;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (hs_cnt !== 32'd5) begin failures++; $display("FAIL ring_head2: issued=%0d want 5", hs_cnt); end
    auto_head = 1'b1;
    wait_drain(50);
  endtask

  task automatic test_fifo_full();
    cmpl_enable_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (complete_ready_o !== 1'b1) begin
        failures++; $display("FAIL fill_ready%0d: ready=%b want 1", i, complete_ready_o);
      end
      push_raw(9'(i * 7), 32'hF000_0000 + 32'(i));
    end
    checks++;
    if (complete_ready_o !== 1'b0 || overflow_err_o !== 1'b0) begin
      failures++; $display("FAIL full_flags: ready=%b ovf=%b want 0 0", complete_ready_o, overflow_err_o);
    end
    push_raw(9'h1FF, 32'h0BAD_0BAD);   // dropped
    checks++;
    if (overflow_err_o !== 1'b1) begin failures++; $display("FAIL overflow_set: ovf=%b want 1", overflow_err_o); end
    cmpl_enable_i = 1'b1; rdy_fixed = 1'b1;
    wait_drain(200);
    checks++;
    if (overflow_err_o !== 1'b1 || complete_ready_o !== 1'b1) begin
      failures++; $display("FAIL overflow_sticky: ovf=%b ready=%b want 1 1", overflow_err_o, complete_ready_o);
    end
  endtask

  task automatic test_random_ready();
    cmpl_base_addr_i = 64'hFFFF_FFFF_FFFF_FFF0;   // address add wraps past 2^64
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) do_push(9'($urandom), $urandom);
    wait_drain(500);
    rand_rdy = 1'b0;
    cmpl_base_addr_i = 64'h1000_0000;
  endtask

  task automatic test_enable_drop();
    logic [31:0] base_hs;
    int t = 0;
    rdy_fixed = 1'b0;
    base_hs = hs_cnt;
    for (int i = 0; i < 3; i++) do_push(9'(i + 100), 32'hE000_0000 + 32'(i));
    while (!wr_req_valid_o && t < 20) begin @(posedge clk); #1; t++; end
    cmpl_enable_i = 1'b0;
    rdy_fixed = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (hs_cnt !== base_hs + 1 || wr_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL enable_hold: issued=%0d valid=%b want %0d 0", hs_cnt - base_hs, wr_req_valid_o, 1);
    end
    cmpl_enable_i = 1'b1;
    wait_drain(50);
    checks++;
    if (hs_cnt !== base_hs + 3) begin failures++; $display("FAIL enable_drain: issued=%0d want 3", hs_cnt - base_hs); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    rdy_fixed = 1'b0;
    for (int i = 0; i < 6; i++) do_push(9'(i + 50), 32'hC000_0000 + 32'(i));
    while (!wr_req_valid_o && t < 20) begin @(posedge clk); #1; t++; end
    apply_reset();
    checks++;
    if (wr_req_valid_o !== 1'b0 || cmpl_cnt_o !== 32'd0 || overflow_err_o !== 1'b0) begin
      failures++; $display("FAIL midreset_state: valid=%b cnt=%0d ovf=%b want 0 0 0", wr_req_valid_o, cmpl_cnt_o, overflow_err_o);
    end
    @(posedge clk); #1;
    checks++;
    if (complete_ready_o !== 1'b1) begin failures++; $display("FAIL midreset_ready: ready=%b want 1", complete_ready_o); end
    push_raw(9'h0C3, 32'h1234_5678);   // expects base addr, seq 0, phase 1
    rdy_fixed = 1'b1;
    wait_drain(50);
    checks++;
    if (cmpl_cnt_o !== 32'd1) begin failures++; $display("FAIL midreset_cnt: cnt=%0d want 1", cmpl_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ring_full();
    test_fifo_full();
    test_random_ready();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
